// File: rtl/toggle_encoder.sv
// D-to-T converter: buffers desired register words in a FIFO and issues per-bit
// toggle vectors against a shadow copy of the downstream toggle flip-flop bank.
module toggle_encoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SKIP_ZERO = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     d_valid,
  output logic                     d_ready,
  input  logic [WIDTH-1:0]         d,
  output logic                     t_valid,
  input  logic                     t_ready,
  output logic [WIDTH-1:0]         t,
  input  logic                     resync,
  output logic [WIDTH-1:0]         shadow,
  output logic [CNT_W-1:0]         toggle_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = CNT_W + 7;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             t_valid_q, t_valid_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             fix_q, fix_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wr_en, load, xfer;
  logic [WIDTH-1:0] head, cur_shadow, next_shadow, tv;
  logic [SW-1:0]    pc, sum;

  assign d_ready    = (level_q != LW'(DEPTH));
  assign wr_en      = d_valid && d_ready;
  assign xfer       = t_valid_q && t_ready;
  assign load       = (!t_valid_q || t_ready) && (level_q != '0);
  assign head       = mem_q[rd_ptr_q];
  // After a resync with a held word, the bank will reach that word once it transfers.
  assign cur_shadow  = fix_q ? word_q : shadow_q;
  assign next_shadow = resync ? '0 : cur_shadow;
  assign tv          = head ^ next_shadow;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= d;
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + SW'(t_q[i]);
    sum   = SW'(cnt_q) + pc;
    cnt_d = cnt_q;
    if (xfer) cnt_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_comb begin
    level_d   = level_q + LW'(wr_en) - LW'(load);
    t_valid_d = t_valid_q;
    t_d       = t_q;
    word_d    = word_q;
    shadow_d  = next_shadow;
    fix_d     = 1'b0;
    if (load) begin
      shadow_d = head;
      word_d   = head;
      if ((SKIP_ZERO != 0) && (tv == '0)) begin
        t_valid_d = 1'b0;
      end else begin
        t_d       = tv;
        t_valid_d = 1'b1;
      end
    end else if (xfer) begin
      t_valid_d = 1'b0;
    end else if (resync && t_valid_q) begin
      // Held word recomputed against a cleared bank.
      t_d   = word_q;
      fix_d = 1'b1;
      if ((SKIP_ZERO != 0) && (word_q == '0)) t_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      t_valid_q <= 1'b0;
      t_q       <= '0;
      word_q    <= '0;
      shadow_q  <= '0;
      fix_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q   <= level_d;
      t_valid_q <= t_valid_d;
      t_q       <= t_d;
      word_q    <= word_d;
      shadow_q  <= shadow_d;
      fix_q     <= fix_d;
      cnt_q     <= cnt_d;
    end
  end

  assign t_valid    = t_valid_q;
  assign t          = t_q;
  assign shadow     = shadow_q;
  assign toggle_cnt = cnt_q;
  assign fifo_level = level_q;

endmodule
